cskip_mw_add_seq: RTL
=====================

# cskip_mw_add_seq

Multi-word add sequencer that time-shares one `CSkipA16` 16-bit carry-skip adder instance to perform WORDS×16-bit additions with carry-in. `CSkipA16` has no carry-in port, so each 16-bit slice takes two adder passes: operand add, then carry increment. The block sits between a requester (valid/ready input) and a consumer (valid/ready output) and owns the only adder instance.

## Interface
- `WORDS`, 4: number of 16-bit slices; operand width N = 16·WORDS; legal range 1..16.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: operand request valid.
- `in_ready` output 1: block idle and able to accept; combinational from state.
- `a` input N: operand A, sampled on the accept edge.
- `b` input N: operand B, sampled on the accept edge.
- `cin` input 1: carry-in, sampled on the accept edge.
- `out_valid` output 1: `sum`/`cout` valid.
- `out_ready` input 1: consumer accepts the result.
- `sum` output N: registered result, bits [N-1:0] of a+b+cin.
- `cout` output 1: registered carry out, bit N of a+b+cin.

## Operation
- Internal: exactly one `CSkipA16` instance, connected positionally (sum, cout, a, b).
- Registers: operand copies A_r and B_r; slice index idx (4 bits); partial P (16 bits); pass-1 carry c1; running carry C; result register.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`: latch a, b; set C←cin, idx←0; go to ADD.
  - ADD: adder inputs are A_r[16·idx +:16] and B_r[16·idx +:16]. At the clock edge: P←adder sum, c1←adder cout; go to INC.
  - INC: adder inputs are P and {15'b0, C}. At the clock edge: sum[16·idx +:16]←adder sum, C←c1|adder cout; if idx==WORDS-1, set `cout`←c1|adder cout and go to DONE; otherwise idx←idx+1 and go to ADD.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE.
- c1 and the INC-pass cout are never both 1; their OR is the exact slice carry.
- INC always executes, even when C=0. Latency is fixed and does not depend on data.
- `in_valid` outside IDLE is ignored. `a`, `b` and `cin` may change freely after the accept edge.
- Adder inputs are 0 in IDLE and DONE.
- `sum` and `cout` hold their last values through IDLE until the next DONE overwrites them. Only `out_valid` qualifies them. Partial slices change `sum` during ADD/INC.

## Timing
- Reset (async assert, any state): state=IDLE, `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0, idx=0, C=c1=P=0. Any in-flight operation is aborted with no output.
- Accept edge at cycle 0. ADD for slice k occupies cycle 2k+1; INC occupies cycle 2k+2.
- `out_valid` rises after the edge ending cycle 2·WORDS, so it is first high in cycle 2·WORDS+1. With the default WORDS=4, that is 8 cycles after the accept edge.
- `out_valid`&&`out_ready` in a DONE cycle: IDLE on the next cycle. The earliest next accept is 1 cycle after the handshake. Minimum period between accepts is 2·WORDS+2 cycles.
- Backpressure: DONE holds indefinitely with `out_valid`, `sum` and `cout` stable.
- `in_ready` is 0 from the accept edge until return to IDLE.
- WORDS=1: ADD, INC, DONE sequence; `out_valid` at cycle 3.

## Test plan
- Reset: drive `rst_n`=0 with random inputs → `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0. Release reset → state stays IDLE.
- Pattern add: a=b=64'hA0A0_A0A0_A0A0_A0A0, `cin`=0 → `sum`=64'h4141_4141_4141_4140, `cout`=1. `out_valid` is first high exactly 8 cycles after the accept edge.
- Full ripple through INC: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, `cin`=1 → `sum`=0, `cout`=1. Check that C=1 after every INC.
- Max operands: a=b=64'hFFFF_FFFF_FFFF_FFFF, `cin`=1 → `sum`=64'hFFFF_FFFF_FFFF_FFFF, `cout`=1.
- Backpressure: complete a=64'h0F3D, b=64'h0F0F (`sum`=64'h1E4C) with `out_ready`=0 for 5 cycles while pulsing `in_valid` → `out_valid` and `sum` are held, `in_ready`=0 and nothing is accepted. Raise `out_ready` → IDLE on the next cycle, `in_ready`=1.
- Reset mid-operation: assert `rst_n`=0 in cycle 3 after an accept → outputs return to reset values immediately and no `out_valid` is produced. After release, run a=1, b=2, `cin`=0 → `sum`=3, `cout`=0 at the normal latency.

Source files
------------

// File: rtl/cskip_mw_add_seq.sv
// Purpose: WORDS x 16-bit add with carry-in, time-sharing one 16-bit carry-skip adder.
// Latency: out_valid first high 2*WORDS cycles after the accept edge (two adder passes per slice).
// Backpressure: holds DONE with sum/cout stable until out_ready; in_ready low while busy.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid / in_ready - request handshake; a, b, cin sampled on the accept edge
//   out_valid/out_ready - result handshake; sum = (a+b+cin)[N-1:0], cout = bit N

module cskip_mw_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [16*WORDS-1:0]  a,
    input  logic [16*WORDS-1:0]  b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [16*WORDS-1:0]  sum,
    output logic                 cout
);
    localparam int N = 16 * WORDS;
    localparam logic [3:0] LAST = 4'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, ADD, INC, DONE} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  a_r, b_r;
    logic [3:0]    idx;
    logic [15:0]   p;
    logic          c1;
    logic          c_run;

    logic [15:0]   add_a, add_b, add_sum;
    logic          add_cout;

    CSkipA16 u_add (add_sum, add_cout, add_a, add_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = 16'h0;
        add_b     = 16'h0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ADD;
            end
            ADD: begin
                add_a     = a_r[16*idx +: 16];
                add_b     = b_r[16*idx +: 16];
                state_nxt = INC;
            end
            INC: begin
                // Second pass folds the running carry into the slice; it runs
                // even when c_run is 0 so latency never depends on data.
                add_a     = p;
                add_b     = {15'b0, c_run};
                state_nxt = (idx == LAST) ? DONE : ADD;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            idx   <= 4'd0;
            p     <= 16'h0;
            c1    <= 1'b0;
            c_run <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        c_run <= cin;
                        idx   <= 4'd0;
                    end
                end
                ADD: begin
                    p  <= add_sum;
                    c1 <= add_cout;
                end
                INC: begin
                    // c1 and the increment carry are mutually exclusive, so
                    // their OR is the exact carry out of this slice.
                    sum[16*idx +: 16] <= add_sum;
                    c_run             <= c1 | add_cout;
                    if (idx == LAST) cout <= c1 | add_cout;
                    else             idx  <= idx + 4'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// 16-bit carry-skip adder, four 4-bit ripple blocks. A block whose bits all
// propagate passes its carry-in straight through instead of waiting on the ripple.
// Combinational, no carry-in port.
module CSkipA16 (
    output logic [15:0] sum,
    output logic        cout,
    input  logic [15:0] a,
    input  logic [15:0] b
);
    logic [15:0] pg;
    logic [15:0] gg;
    logic        blk_c;
    logic        rc;

    assign pg = a ^ b;
    assign gg = a & b;

    always_comb begin
        sum   = 16'h0;
        blk_c = 1'b0;
        rc    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rc = blk_c;
            for (int j = 0; j < 4; j++) begin
                sum[4*k+j] = pg[4*k+j] ^ rc;
                rc         = gg[4*k+j] | (pg[4*k+j] & rc);
            end
            blk_c = (&pg[4*k +: 4]) ? blk_c : rc;
        end
        cout = blk_c;
    end
endmodule
